// File: rtl/instr_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_serializer_if
//  Description : Opcode offer handshake between a driver and instr_serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_serializer_if;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_code;
    logic       op_clear;

    modport master (output op_valid, output op_code, output op_clear, input  op_ready);
    modport slave  (input  op_valid, input  op_code, input  op_clear, output op_ready);
endinterface
`default_nettype wire

// File: rtl/instr_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_serializer
//  Description : Serialises a 4-bit opcode LSB-first onto the ALU instruction
//                load pins, with an optional instruction-register clear first.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_serializer #(
    parameter int unsigned GAP_CYCLES   = 50,
    parameter int unsigned PULSE_CYCLES = 50,
    parameter int unsigned CLR_CYCLES   = 150
) (
    input  wire logic             clk,
    input  wire logic             reset_all,
    instr_serializer_if.slave     op_if,
    output logic                  instr_bit,
    output logic                  instr_load_en,
    output logic                  reset_instr,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned c_MAX_GP = (GAP_CYCLES > PULSE_CYCLES) ? GAP_CYCLES : PULSE_CYCLES;
    localparam int unsigned c_MAX    = (c_MAX_GP > CLR_CYCLES) ? c_MAX_GP : CLR_CYCLES;
    localparam int unsigned c_CNT_W  = (c_MAX > 1) ? $clog2(c_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CLR_LAST   = c_CNT_W'(CLR_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_LOAD  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_code;
    logic               r_bit;
    logic               r_load_en;
    logic               r_reset_n;
    logic               r_busy;
    logic               r_done;
    logic               w_accept;

    // Ready is the only combinational output; it drops as soon as reset rises.
    assign op_if.op_ready = (r_state == S_IDLE) && !reset_all;
    assign w_accept       = op_if.op_valid && op_if.op_ready;

    assign instr_bit     = r_bit;
    assign instr_load_en = r_load_en;
    assign reset_instr   = r_reset_n;
    assign busy          = r_busy;
    assign done          = r_done;

    always_ff @(posedge clk) begin
        if (reset_all) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_cnt     <= '0;
            r_code    <= 4'd0;
            r_bit     <= 1'b0;
            r_load_en <= 1'b0;
            r_reset_n <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_code <= op_if.op_code;
                        r_idx  <= 2'd0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (op_if.op_clear) begin
                            r_state   <= S_CLEAR;
                            r_reset_n <= 1'b0;
                        end else begin
                            r_state <= S_GAP;
                            r_bit   <= op_if.op_code[0];
                        end
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == c_CLR_LAST) begin
                        r_cnt     <= '0;
                        r_state   <= S_GAP;
                        r_reset_n <= 1'b1;
                        r_bit     <= r_code[r_idx];
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt     <= '0;
                        r_state   <= S_LOAD;
                        r_load_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == c_PULSE_LAST) begin
                        r_cnt     <= '0;
                        r_load_en <= 1'b0;
                        if (r_idx == 2'd3) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            // The bit only moves on GAP entry so it is settled before the pulse.
                            r_idx   <= r_idx + 2'd1;
                            r_state <= S_GAP;
                            r_bit   <= r_code[r_idx + 2'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_serializer
//  Description : Self-checking bench for instr_serializer against a per-cycle
//                timing model derived from the gap/pulse/clear arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_serializer;

    localparam int c_GAP   = 3;
    localparam int c_PULSE = 2;
    localparam int c_CLR   = 4;
    localparam int c_BIT   = c_GAP + c_PULSE;

    logic clk;
    logic reset_all;
    logic instr_bit;
    logic instr_load_en;
    logic reset_instr;
    logic busy;
    logic done;

    int   n_checks;
    int   n_fail;
    logic last_bit;
    logic nxt_valid;
    logic nxt_clr;
    logic [3:0] nxt_code;

    instr_serializer_if op_if ();

    instr_serializer #(
        .GAP_CYCLES   (c_GAP),
        .PULSE_CYCLES (c_PULSE),
        .CLR_CYCLES   (c_CLR)
    ) u_dut (
        .clk           (clk),
        .reset_all     (reset_all),
        .op_if         (op_if.slave),
        .instr_bit     (instr_bit),
        .instr_load_en (instr_load_en),
        .reset_instr   (reset_instr),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // One full transfer, starting at a negedge with the block idle.
    // chain=1 means the opcode was already presented in the previous done cycle.
    task automatic xfer(input logic [3:0] code, input logic clr, input bit hold, input bit chain);
        int         c_len;
        int         total;
        int         u;
        logic       busy_e;
        logic       le_e;
        logic       bit_e;
        logic       prev_le;
        logic [3:0] recon;
        c_len = clr ? c_CLR : 0;
        total = c_len + 4 * c_BIT + 1;
        if (!chain) begin
            op_if.op_valid = 1'b1;
            op_if.op_code  = code;
            op_if.op_clear = clr;
        end
        check("ready_at_offer", op_if.op_ready, 1'b1);
        @(posedge clk);
        recon   = 4'd0;
        prev_le = 1'b0;
        for (int t = 1; t <= total; t++) begin
            @(negedge clk);
            busy_e = (t < total);
            if (t <= c_len) begin
                le_e  = 1'b0;
                bit_e = last_bit;
            end else if (busy_e) begin
                u     = t - c_len - 1;
                le_e  = ((u % c_BIT) >= c_GAP);
                bit_e = code[u / c_BIT];
            end else begin
                le_e  = 1'b0;
                bit_e = code[3];
            end
            check("busy",        busy,           busy_e);
            check("done",        done,           !busy_e);
            check("op_ready",    op_if.op_ready, !busy_e);
            check("reset_instr", reset_instr,    !(t <= c_len));
            check("load_en",     instr_load_en,  le_e);
            check("instr_bit",   instr_bit,      bit_e);
            if (instr_load_en === 1'b1 && prev_le === 1'b0)
                recon = {instr_bit, recon[3:1]};
            prev_le = instr_load_en;
            if (t == total) begin
                op_if.op_valid = nxt_valid;
                op_if.op_code  = nxt_code;
                op_if.op_clear = nxt_clr;
            end else begin
                op_if.op_valid = hold;
                op_if.op_code  = 4'($urandom);
                op_if.op_clear = 1'($urandom);
            end
        end
        check("reconstructed_opcode", recon, code);
        last_bit = code[3];
    endtask

    initial begin
        int         perm[16];
        int         j;
        int         tmp;
        logic       cur_clr;
        n_checks       = 0;
        n_fail         = 0;
        last_bit       = 1'b0;
        nxt_valid      = 1'b0;
        nxt_code       = 4'd0;
        nxt_clr        = 1'b0;
        reset_all      = 1'b1;
        op_if.op_valid = 1'b0;
        op_if.op_code  = 4'd0;
        op_if.op_clear = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_op_ready",    op_if.op_ready, 1'b0);
        check("rst_busy",        busy,           1'b0);
        check("rst_done",        done,           1'b0);
        check("rst_load_en",     instr_load_en,  1'b0);
        check("rst_reset_instr", reset_instr,    1'b1);
        check("rst_instr_bit",   instr_bit,      1'b0);
        reset_all = 1'b0;
        @(negedge clk);
        check("ready_after_rst", op_if.op_ready, 1'b1);

        xfer(4'b1011, 1'b0, 1'b0, 1'b0);
        xfer(4'b1100, 1'b1, 1'b0, 1'b0);

        // A held offer while busy must only be taken in the done cycle.
        nxt_valid = 1'b1;
        nxt_code  = 4'b1111;
        nxt_clr   = 1'b0;
        xfer(4'b1000, 1'b0, 1'b1, 1'b0);
        nxt_valid = 1'b0;
        xfer(4'b1111, 1'b0, 1'b0, 1'b1);

        xfer(4'b1001, 1'b0, 1'b0, 1'b0);

        // Reset raised in cycle 2 of a clearing transfer.
        op_if.op_valid = 1'b1;
        op_if.op_code  = 4'b1111;
        op_if.op_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_if.op_valid = 1'b0;
        check("mid_clear_rstn_c1", reset_instr, 1'b0);
        @(negedge clk);
        check("mid_clear_rstn_c2", reset_instr, 1'b0);
        reset_all = 1'b1;
        #1;
        check("ready_in_reset", op_if.op_ready, 1'b0);
        @(negedge clk);
        check("abort_reset_instr", reset_instr,   1'b1);
        check("abort_load_en",     instr_load_en, 1'b0);
        check("abort_instr_bit",   instr_bit,     1'b0);
        check("abort_busy",        busy,          1'b0);
        check("abort_done",        done,          1'b0);
        reset_all = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("post_abort_load_en", instr_load_en,  1'b0);
            check("post_abort_done",    done,           1'b0);
            check("post_abort_rstn",    reset_instr,    1'b1);
            check("post_abort_ready",   op_if.op_ready, 1'b1);
        end
        last_bit = 1'b0;

        // All 16 opcodes back-to-back in random order with random clears.
        for (int i = 0; i < 16; i++) perm[i] = i;
        for (int i = 15; i > 0; i--) begin
            j       = int'($urandom_range(i, 0));
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        cur_clr = 1'($urandom);
        for (int i = 0; i < 16; i++) begin
            if (i < 15) begin
                nxt_valid = 1'b1;
                nxt_code  = 4'(perm[i + 1]);
                nxt_clr   = 1'($urandom);
            end else begin
                nxt_valid = 1'b0;
                nxt_code  = 4'd0;
                nxt_clr   = 1'b0;
            end
            xfer(4'(perm[i]), cur_clr, 1'($urandom), (i > 0));
            cur_clr = nxt_clr;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_serializer.md
# instr_serializer

Transmit side of the ALU's serial instruction-load interface. Accepts a 4-bit opcode over a valid/ready handshake and produces the `instruction_in` / `instr_load_en` / `reset_instr` sequence that `alu_top` expects: LSB first, one bit per load-enable pulse. It can optionally clear the ALU instruction register first. It replaces hand-timed bench sequencing and is the front end for the board-level opcode driver.

## Interface

Parameters:
- `GAP_CYCLES`, default 50: cycles with `instr_load_en` low and the bit held before each pulse (setup time). Must be ≥1.
- `PULSE_CYCLES`, default 50: cycles with `instr_load_en` high per bit. Must be ≥1.
- `CLR_CYCLES`, default 150: cycles with `reset_instr` held low when a clear is requested. Must be ≥1.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset_all` input 1: synchronous, active-high reset.
- `op_valid` input 1: an opcode is offered.
- `op_ready` output 1: block is in IDLE and not in reset. Combinational from the state register, gated by `reset_all`.
- `op_code` input 4: opcode. Transmission order is bit0 first.
- `op_clear` input 1: sampled with `op_code`. When 1, a CLEAR phase runs before the bits.
- `instr_bit` output 1: drives `alu_top.instruction_in`.
- `instr_load_en` output 1: drives `alu_top.instr_load_en`.
- `reset_instr` output 1: drives `alu_top.reset_instr`. Active-low.
- `busy` output 1: high in any non-IDLE state.
- `done` output 1: one-cycle pulse after the 4th bit's pulse ends.

## Operation

- States are IDLE, CLEAR, GAP, LOAD. There is a 2-bit bit index and one shared phase counter wide enough for max(GAP, PULSE, CLR) − 1.
- Accept: a transfer occurs when `op_valid && op_ready` at a rising edge. At that edge, `op_code` and `op_clear` are latched. Later changes to the inputs have no effect.
- IDLE → CLEAR if `op_clear`, otherwise IDLE → GAP. Bit index is set to 0.
- CLEAR: `reset_instr`=0 for CLR_CYCLES cycles, `instr_load_en`=0. Then → GAP.
- GAP: `instr_bit` = latched bit[index], `instr_load_en`=0, for GAP_CYCLES cycles. Then → LOAD.
- LOAD: `instr_bit` = bit[index], `instr_load_en`=1, for PULSE_CYCLES cycles.
  - If index<3: index++ and → GAP.
  - If index=3: → IDLE with `done`=1.
- `instr_bit` is stable for the whole GAP+LOAD window of each bit. It changes only on GAP entry.
- In IDLE, `instr_bit` holds its last value, `instr_load_en`=0, `reset_instr`=1.
- `op_valid` while busy is ignored. Nothing is queued.

## Timing

- Reset values, applied on the edge with `reset_all`=1:
  - state IDLE, index 0, counter 0
  - `instr_bit`=0, `instr_load_en`=0, `reset_instr`=1, `busy`=0, `done`=0
  - `op_ready`=0 while `reset_all` is high
- All outputs except `op_ready` are registered.
- Accept at edge 0. Cycle 1 is the first cycle of CLEAR, or of GAP if there is no clear.
- Busy length is C + 4·(GAP_CYCLES+PULSE_CYCLES) cycles, where C = CLR_CYCLES if clearing, else 0.
- `done` is high in cycle C + 4·(GAP+PULSE) + 1. That is the first IDLE cycle, where `op_ready`=1.
- Back-to-back: an opcode offered in the `done` cycle is accepted there. Its GAP/CLEAR starts the next cycle, so there are zero idle cycles between transfers.
- Reset mid-operation: on the next edge all outputs take their reset values. `instr_load_en` drops immediately, the latched opcode is discarded, and no `done` is produced.
- A reset during CLEAR releases `reset_instr` (sets it to 1) on that edge.

## Test plan

All scenarios use GAP_CYCLES=3, PULSE_CYCLES=2, CLR_CYCLES=4, with accept at edge 0.

1. Opcode 4'b1011, no clear.
   - `instr_load_en` is high in cycles 4-5, 9-10, 14-15, 19-20, with `instr_bit` = 1, 1, 0, 1 respectively.
   - `busy` is high in cycles 1-20; `done` and `op_ready` are high in cycle 21.
2. Opcode 4'b1100 with `op_clear`=1.
   - `reset_instr`=0 in cycles 1-4.
   - Pulses in cycles 8-9, 13-14, 18-19, 23-24 with bits 0, 0, 1, 1.
   - `done` in cycle 25.
3. Offer 4'b1000, then hold `op_valid` with 4'b1111 throughout.
   - The second opcode is accepted only at edge 21.
   - Its first GAP is cycles 22-24 and its pulse bits are all 1.
   - No pulses overlap the first transfer.
4. Opcode 4'b1001, then change `op_code` to 4'b0110 at cycle 2.
   - The transmitted bits remain 1, 0, 0, 1.
5. Opcode 4'b1111 with clear, and `reset_all` pulsed at cycle 2.
   - At cycle 3: `reset_instr`=1, `instr_load_en`=0, `instr_bit`=0, `busy`=0.
   - There are no further pulses and no `done`.
   - `op_ready` returns after reset is released.
6. Sweep all 16 opcodes back-to-back.
   - A scoreboard shifts in `instr_bit` on each `instr_load_en` rising edge; every opcode is reconstructed exactly.
   - A loopback to `alu_top` gives the matching `bcd_result` for A=6'b010101, B=6'b010001.
